// File: rtl/switch_debounce_and.sv
// rtl/switch_debounce_and.sv - two-channel switch synchronizer/debouncer with edge pulses and AND-driven LED (option: LED_TOGGLE_EN)
module switch_debounce_and_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic {STABLE, PENDING} state_t;

    state_t           state, state_next;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             level_next, rise_next, fall_next, commit;

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            STABLE: begin
                if (s2 != level) begin
                    if (LIMIT <= CNT_W'(1)) begin
                        commit = 1'b1;
                    end else begin
                        state_next = PENDING;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (s2 == level) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_inc >= LIMIT) begin
                    commit = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
        // A commit always clears the counter, so it can never wrap.
        if (commit) begin
            state_next = STABLE;
            cnt_next   = '0;
        end
        level_next = commit ? ~level : level;
        rise_next  = commit & ~level;
        fall_next  = commit & level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end
endmodule

module switch_debounce_and #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic switch_a,
    input  logic switch_b,
    output logic a_level,
    output logic b_level,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic led
);
    logic conj;

    switch_debounce_and_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (switch_a),
        .level (a_level),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    switch_debounce_and_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (switch_b),
        .level (b_level),
        .rise  (b_rise),
        .fall  (b_fall)
    );

    assign conj = a_level & b_level;

`ifdef LED_TOGGLE_EN
    logic conj_d;

    // Toggle only on the 0->1 edge of the conjunction; its falling edge is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conj_d <= 1'b0;
            led    <= 1'b0;
        end else begin
            conj_d <= conj;
            led    <= led ^ (conj & ~conj_d);
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 1'b0;
        end else begin
            led <= conj;
        end
    end
`endif
endmodule

// File: doc/switch_debounce_and.md
# switch_debounce_and

Conditions two raw, asynchronous, bouncing slide-switch inputs into clean debounced levels and single-cycle edge pulses, and drives an LED from the conjunction of the debounced levels. It is the input-side counterpart to the combinational switch-to-LED logic. It sits between the board switch pins and any logic that consumes switch state, removing metastability and contact bounce before the signals are used.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive clock cycles a synchronized input must differ from its committed level before the level flips (10 ms at 100 MHz); legal range ≥ 1.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): counter width; derived, not overridden.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- switch_a  input  1  raw switch A, asynchronous to clk.
- switch_b  input  1  raw switch B, asynchronous to clk.
- a_level  output  1  debounced level of A.
- b_level  output  1  debounced level of B.
- a_rise, a_fall  output  1 each  one-cycle pulse when a_level goes 0→1 or 1→0.
- b_rise, b_fall  output  1 each  one-cycle pulse when b_level goes 0→1 or 1→0.
- led  output  1  LED drive; see Configuration.

## Operation
- Per channel, two identical instances: a 2-flop synchronizer (s1, s2), a CNT_W-bit counter, and the committed level register.
- States per channel: STABLE (s2 == level, counter = 0) and PENDING (s2 != level, counter counting).
- STABLE → PENDING when s2 != level; counter becomes 1 on that edge.
- PENDING, s2 still != level, counter < DEBOUNCE_CYCLES: counter increments.
- PENDING, s2 != level and counter reaches DEBOUNCE_CYCLES: level inverts, counter clears, and the matching rise/fall pulse asserts for exactly one cycle. Return to STABLE.
- PENDING, s2 == level (a bounce back): counter clears to 0 and the channel returns to STABLE with no level change and no pulse.
- The counter saturates logic-wise; it never wraps, because a commit always clears it.
- Channels are fully independent. Simultaneous commits on A and B in the same cycle are legal, and both pulses assert together.
- rise and fall of one channel are never asserted in the same cycle.

## Timing
- Reset values: s1, s2, counters, a_level, b_level, all pulses, and led are 0. Reset is honoured immediately, whether mid-count or mid-pulse.
- After reset deasserts with a switch already held high, the full debounce latency applies before the level asserts. No pulse occurs during reset.
- Latency: raw input sampled at a new value on edge N reaches s2 on edge N+1. The level flips on edge N+1+DEBOUNCE_CYCLES, provided the input holds.
- Any glitch shorter than DEBOUNCE_CYCLES cycles, as seen at s2, produces no output activity.
- Pulses are asserted in the same cycle that the level changes, and last one cycle.
- led is registered and updates one edge after a_level and b_level change.

## Configuration
- Macro: LED_TOGGLE_EN.
- Undefined (default): led <= a_level & b_level, registered. led follows the debounced AND with one cycle of delay.
- Defined: led toggles once on each cycle in which (a_level & b_level) transitions 0→1. The falling of the conjunction leaves led unchanged. led resets to 0.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=8.
- Reset release with both switches held at 1 → a_level, b_level and led stay 0 through reset. Each level goes to 1 exactly 9 edges after the first sampling edge, with one a_rise and one b_rise pulse. led is 1 one edge later.
- switch_a toggles 1,0,1,0 with 3-cycle spacing, then holds 1 → no a_rise until 8 consecutive differing s2 cycles. Exactly one a_rise pulse is produced and a_level = 1.
- a_level = b_level = 1, then switch_b drops to 0 and holds → one b_fall pulse at the expected edge. led falls one edge later (macro undefined) or stays 1 (macro defined).
- Both switches change on the same cycle → a_rise and b_rise assert in the same cycle, and neither fall pulse asserts.
- reset asserted while counter = 5 on channel A → all outputs 0 immediately. After release with the switch still held, the full 9-edge latency is required again.
- LED_TOGGLE_EN defined: three separate A&B assertions → led sequence 0→1→0→1, toggling only on conjunction rises.
